// File: rtl/music_player_ctrl_pkg.sv
// Shared types and constants for the music player: FSM state codes, octave
// selection, note-frequency table, note-word decode helpers and the note-word width.
`ifndef DATA_WIDTH
`define DATA_WIDTH 10
`endif

package music_player_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    OCT_MID  = 2'd0,
    OCT_LOW  = 2'd1,
    OCT_HIGH = 2'd2
  } octave_e;

  // Middle-octave do..si frequencies in centi-hertz.
  localparam int unsigned NOTE_FREQ_CHZ [7] = '{26163, 29366, 32963, 34923, 39200, 44000, 49388};

  // Seven middle-octave half-periods round(clk_freq / (2*f)), packed 32 bits each.
  function automatic logic [7*32-1:0] hp_table(input logic [63:0] clk_freq);
    logic [7*32-1:0] tab;
    logic [63:0]     num;
    logic [63:0]     den;
    tab = '0;
    for (int i = 0; i < 7; i++) begin
      den = 64'd2 * 64'(NOTE_FREQ_CHZ[i]);
      num = clk_freq * 64'd100 + 64'(NOTE_FREQ_CHZ[i]);
      tab[i*32 +: 32] = 32'(num / den);
    end
    return tab;
  endfunction

  // Lowest set bit wins; an all-zero field is a rest (0).
  function automatic logic [2:0] note_of(input logic [6:0] bits);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (bits[i]) idx = 3'(i + 1);
    end
    return idx;
  endfunction

  function automatic octave_e octave_of(input logic hi, input logic lo);
    octave_e oct;
    oct = OCT_MID;
    if (hi)      oct = OCT_HIGH;
    else if (lo) oct = OCT_LOW;
    return oct;
  endfunction

endpackage

// File: rtl/music_player_ctrl_tone_gen.sv
// Square-wave tone generator: octave-shifted, saturating half-period counter that
// restarts from a low output whenever the selected note changes.
module tone_gen
  import music_player_ctrl_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100000000,
  parameter int          HP_WIDTH = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] note_idx,
  input  octave_e    octave,
  output logic       tone
);

  localparam logic [7*32-1:0] HP_TAB = hp_table(64'(CLK_FREQ));
  localparam logic [32:0]     HP_MAX = 33'((64'd1 << HP_WIDTH) - 64'd1);

  logic [31:0]         base;
  logic [32:0]         scaled;
  logic [HP_WIDTH-1:0] half_period;
  logic [HP_WIDTH-1:0] cnt_q, cnt_d;
  logic                tone_q, tone_d;
  logic [4:0]          key_q, key_d;
  logic                key_same;

  always_comb begin
    base = 32'd0;
    for (int i = 0; i < 7; i++) begin
      if (note_idx == 3'(i + 1)) base = HP_TAB[i*32 +: 32];
    end
    case (octave)
      OCT_LOW:  scaled = {base, 1'b0};
      OCT_HIGH: scaled = {2'b00, base[31:1]};
      default:  scaled = {1'b0, base};
    endcase
    // Saturate instead of wrapping; never let the period collapse to zero.
    if (scaled > HP_MAX)       half_period = '1;
    else if (scaled == 33'd0)  half_period = HP_WIDTH'(1);
    else                       half_period = scaled[HP_WIDTH-1:0];
  end

  always_comb begin
    key_d    = {octave, note_idx};
    key_same = (key_d == key_q);
    cnt_d    = '0;
    tone_d   = 1'b0;
    if ((note_idx != 3'd0) && key_same) begin
      if (cnt_q == half_period - HP_WIDTH'(1)) begin
        tone_d = ~tone_q;
      end else begin
        cnt_d  = cnt_q + HP_WIDTH'(1);
        tone_d = tone_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tone_q <= 1'b0;
      key_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      tone_q <= tone_d;
      key_q  <= key_d;
    end
  end

  // Mask the stale level during the cycle a new note (or silence) is selected.
  assign tone = tone_q & key_same & (note_idx != 3'd0);

endmodule

// File: rtl/music_player_ctrl.sv
// Music player controller: play/pause/stop FSM sequencing a note memory and driving
// a buzzer through tone_gen. Define VOLUME_PWM_EN to add a 2-bit volume PWM gate.
`ifndef DATA_WIDTH
`define DATA_WIDTH 10
`endif

module music_player_ctrl
  import music_player_ctrl_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100000000,
  parameter int          HP_WIDTH = 20
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   play,
  input  logic                   pause,
  input  logic                   stop,
  input  logic [`DATA_WIDTH-1:0] data_in,
  input  logic                   data_valid,
`ifdef VOLUME_PWM_EN
  input  logic [1:0]             volume,
`endif
  output logic                   read_en,
  output logic                   read_rst,
  output logic                   buzzer,
  output logic [2:0]             state_o,
  output logic [2:0]             note_idx
);

  // Memory handshake: read_en high advances the memory one word per cycle, read_rst
  // rewinds it; data_valid high marks data_in as a note word, and a 1->0 fall of
  // data_valid on consecutive PLAY cycles marks the end of the song.
  state_e     state_q, state_d;
  logic       read_en_q, read_en_d;
  logic       read_rst_q, read_rst_d;
  logic       dv_prev_q, dv_prev_d;
  logic [8:0] note_q, note_d;
  logic [2:0] raw_idx;
  octave_e    octave;
  logic       tone;
  logic       unused_hi_bits;

  assign unused_hi_bits = ^data_in[`DATA_WIDTH-1:9];

  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (play) state_d = ST_START;
        ST_START: state_d = ST_PLAY;
        ST_PLAY: begin
          if (pause)                         state_d = ST_PAUSE;
          else if (dv_prev_q && !data_valid) state_d = ST_DONE;
        end
        ST_PAUSE: if (play) state_d = ST_PLAY;
        ST_DONE:  if (play) state_d = ST_START;
        default:  state_d = ST_IDLE;
      endcase
    end

    read_rst_d = stop || (state_d == ST_START);
    read_en_d  = (state_q == ST_PLAY) && (state_d == ST_PLAY);
    dv_prev_d  = (state_q == ST_PLAY) && data_valid;

    // PAUSE and DONE keep the last word so a resume replays the same note.
    note_d = note_q;
    if ((state_q == ST_IDLE) || (state_q == ST_START)) note_d = '0;
    else if ((state_q == ST_PLAY) && data_valid)       note_d = data_in[8:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      read_en_q  <= 1'b0;
      read_rst_q <= 1'b1;
      dv_prev_q  <= 1'b0;
      note_q     <= '0;
    end else begin
      state_q    <= state_d;
      read_en_q  <= read_en_d;
      read_rst_q <= read_rst_d;
      dv_prev_q  <= dv_prev_d;
      note_q     <= note_d;
    end
  end

  assign raw_idx  = note_of(note_q[6:0]);
  assign octave   = octave_of(note_q[8], note_q[7]);
  assign note_idx = (state_q == ST_PLAY) ? raw_idx : 3'd0;

  tone_gen #(
    .CLK_FREQ (CLK_FREQ),
    .HP_WIDTH (HP_WIDTH)
  ) u_tone_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .note_idx (note_idx),
    .octave   (octave),
    .tone     (tone)
  );

`ifdef VOLUME_PWM_EN
  logic [1:0] pwm_cnt_q, pwm_cnt_d;

  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_cnt_q <= 2'd0;
    else        pwm_cnt_q <= pwm_cnt_d;
  end

  assign buzzer = tone & ({1'b0, pwm_cnt_q} < ({1'b0, volume} + 3'd1));
`else
  assign buzzer = tone;
`endif

  assign read_en  = read_en_q;
  assign read_rst = read_rst_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_music_player_ctrl.sv
// Self-checking bench for music_player_ctrl: per-cycle model comparison plus
// directed scenarios with hand-computed values at a 200 kHz clock and 9-bit counter.
module tb_music_player_ctrl;

  localparam int CLK_FREQ = 200000;
  localparam int HPW      = 9;

  logic       clk;
  logic       rst_n;
  logic       play, pause, stop;
  logic [9:0] data_in;
  logic       data_valid;
  logic       read_en, read_rst, buzzer;
  logic [2:0] state_o, note_idx;
`ifdef VOLUME_PWM_EN
  logic [1:0] volume;
`endif

  music_player_ctrl #(
    .CLK_FREQ (CLK_FREQ),
    .HP_WIDTH (HPW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .play       (play),
    .pause      (pause),
    .stop       (stop),
    .data_in    (data_in),
    .data_valid (data_valid),
`ifdef VOLUME_PWM_EN
    .volume     (volume),
`endif
    .read_en    (read_en),
    .read_rst   (read_rst),
    .buzzer     (buzzer),
    .state_o    (state_o),
    .note_idx   (note_idx)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  real freq [7] = '{261.63, 293.66, 329.63, 349.23, 392.00, 440.00, 493.88};

  // oct: 0 mid, 1 low, 2 high
  function automatic int hp_model(input int idx, input int oct);
    int base;
    int hp;
    int lim;
    base = $rtoi(CLK_FREQ / (2.0 * freq[idx-1]) + 0.5);
    if (oct == 1)      hp = base * 2;
    else if (oct == 2) hp = base / 2;
    else               hp = base;
    lim = (1 << HPW) - 1;
    if (hp > lim) hp = lim;
    if (hp < 1)   hp = 1;
    return hp;
  endfunction

  // Sounding note as oct*8+idx, 0 when silent.
  function automatic int key_of(input int st, input logic [9:0] w);
    int idx;
    int oct;
    idx = 0;
    for (int b = 0; b < 7; b++) begin
      if (w[b] && idx == 0) idx = b + 1;
    end
    if (st != 2 || idx == 0) return 0;
    oct = w[8] ? 2 : (w[7] ? 1 : 0);
    return oct * 8 + idx;
  endfunction

  int         m_st, m_key, m_k, m_start;
  logic       m_rst, m_ren, m_dvp, m_ready;
  logic [9:0] m_note;

  initial m_ready = 1'b0;

  always @(posedge clk or negedge rst_n) begin : model
    int nxt;
    int nk;
    if (!rst_n) begin
      m_st = 0; m_rst = 1'b1; m_ren = 1'b0; m_dvp = 1'b0; m_note = '0;
      m_key = 0; m_k = 0; m_start = 0; m_ready = 1'b1;
    end else begin
      nxt = m_st;
      if (stop) nxt = 0;
      else if (m_st == 0 && play) nxt = 1;
      else if (m_st == 1) nxt = 2;
      else if (m_st == 2 && pause) nxt = 3;
      else if (m_st == 2 && m_dvp && !data_valid) nxt = 4;
      else if (m_st == 3 && play) nxt = 2;
      else if (m_st == 4 && play) nxt = 1;
      m_rst = stop || (nxt == 1);
      m_ren = (m_st == 2) && (nxt == 2);
      if (m_st == 0 || m_st == 1) m_note = '0;
      else if (m_st == 2 && data_valid) m_note = data_in;
      m_dvp = (m_st == 2) && data_valid;
      m_st  = nxt;
      m_k++;
      nk = key_of(m_st, m_note);
      if (nk != m_key) m_start = m_k;
      m_key = nk;
    end
  end

  always @(negedge clk) begin : compare
    int idx;
    int t;
    if (m_ready) begin
      idx = m_key % 8;
      if (idx == 0 || m_k == m_start) t = 0;
      else t = ((m_k - m_start - 1) / hp_model(idx, m_key / 8)) % 2;
`ifdef VOLUME_PWM_EN
      if ((m_k % 4) >= int'(volume) + 1) t = 0;
`endif
      check("state_o",  int'(state_o),  m_st);
      check("read_rst", int'(read_rst), int'(m_rst));
      check("read_en",  int'(read_en),  int'(m_ren));
      check("note_idx", int'(note_idx), idx);
      check("buzzer",   int'(buzzer),   t);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse_play();
    play = 1'b1; tick(1); play = 1'b0;
  endtask

  // Cycles between two successive rising edges of buzzer; -1 if none in budget.
  task automatic measure_period(output int per);
    int r1, r2, c;
    logic prev;
    r1 = -1; r2 = -1; c = 0; prev = buzzer;
    while (r2 < 0 && c < 4000) begin
      @(negedge clk);
      c++;
      if (buzzer && !prev) begin
        if (r1 < 0) r1 = c;
        else        r2 = c;
      end
      prev = buzzer;
    end
    per = (r2 < 0) ? -1 : r2 - r1;
    @(posedge clk); #2;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int per;
    int highs;
    play = 1'b0; pause = 1'b0; stop = 1'b0; data_in = '0; data_valid = 1'b0;
`ifdef VOLUME_PWM_EN
    volume = 2'd3;
`endif
    rst_n = 1'b0;

    // pin the model's half-period arithmetic at 200 kHz
    check("model_hp_mi_mid",  hp_model(3, 0), 303);
    check("model_hp_do_high", hp_model(1, 2), 191);
    check("model_hp_do_low",  hp_model(1, 1), 511);

    tick(3);
    @(negedge clk);
    check("rst_state",    int'(state_o),  0);
    check("rst_read_rst", int'(read_rst), 1);
    check("rst_read_en",  int'(read_en),  0);
    check("rst_buzzer",   int'(buzzer),   0);
    check("rst_note_idx", int'(note_idx), 0);
    rst_n = 1'b1;
    tick(2);

    // play: IDLE -> START -> PLAY, read_en one cycle after PLAY
    pulse_play();
    data_in = 10'b0000000100; data_valid = 1'b1;
    @(negedge clk);
    check("start_state",    int'(state_o),  1);
    check("start_read_rst", int'(read_rst), 1);
    tick(1); @(negedge clk);
    check("play_state",    int'(state_o),  2);
    check("play_read_rst", int'(read_rst), 0);
    check("play_read_en0", int'(read_en),  0);
    tick(1); @(negedge clk);
    check("play_read_en1", int'(read_en),  1);
    check("mi_note_idx",   int'(note_idx), 3);
    tick(0);
    @(posedge clk); #2;
    measure_period(per);
    check("mi_period", per, 606);

    // high-octave do, then low-octave do which saturates the 9-bit counter
    data_in = 10'b0100000001;
    tick(1); @(negedge clk);
    check("do_hi_note_idx", int'(note_idx), 1);
    @(posedge clk); #2;
    measure_period(per);
    check("do_hi_period", per, 382);
    data_in = 10'b0010000001;
    tick(1); @(negedge clk);
    check("do_lo_note_idx", int'(note_idx), 1);
    @(posedge clk); #2;
    measure_period(per);
    check("do_lo_sat_period", per, 1022);

    // rest: silent
    data_in = 10'b0000000000;
    tick(1);
    highs = 0;
    repeat (50) begin
      @(negedge clk);
      if (buzzer) highs++;
    end
    check("rest_note_idx", int'(note_idx), 0);
    check("rest_silent", highs, 0);
    @(posedge clk); #2;

    // pause mid-note, then resume the same note without a rewind
    data_in = 10'b0000000100;
    tick(400);
    pause = 1'b1; tick(1); pause = 1'b0;
    @(negedge clk);
    check("pause_state",   int'(state_o), 3);
    check("pause_read_en", int'(read_en), 0);
    check("pause_buzzer",  int'(buzzer),  0);
    tick(1);
    tick(3);
    pulse_play();
    @(negedge clk);
    check("resume_state",    int'(state_o),  2);
    check("resume_read_rst", int'(read_rst), 0);
    @(posedge clk); #2;
    measure_period(per);
    check("resume_period",   per, 606);
    check("resume_note_idx", int'(note_idx), 3);

    // end of song
    data_valid = 1'b0;
    tick(1); @(negedge clk);
    check("done_state",   int'(state_o), 4);
    check("done_read_en", int'(read_en), 0);
    @(posedge clk); #2;

    // DONE -> START -> PLAY, then stop and play together
    pulse_play();
    tick(1);
    stop = 1'b1; play = 1'b1;
    tick(1);
    stop = 1'b0; play = 1'b0;
    @(negedge clk);
    check("stop_state",    int'(state_o),  0);
    check("stop_read_rst", int'(read_rst), 1);
    @(posedge clk); #2;

    // reset mid-song behaves as a stop
    pulse_play();
    data_in = 10'b0000000100; data_valid = 1'b1;
    tick(700);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_state",    int'(state_o),  0);
    check("midrst_buzzer",   int'(buzzer),   0);
    check("midrst_read_rst", int'(read_rst), 1);
    check("midrst_note_idx", int'(note_idx), 0);
    tick(2);
    rst_n = 1'b1;
    @(negedge clk);
    check("release_read_rst_hold", int'(read_rst), 1);
    tick(1); @(negedge clk);
    check("release_read_rst_drop", int'(read_rst), 0);
    @(posedge clk); #2;
    pulse_play();
    tick(1); @(negedge clk);
    check("restart_note_idx0", int'(note_idx), 0);
    tick(1); @(negedge clk);
    check("restart_note_idx3", int'(note_idx), 3);
    @(posedge clk); #2;

`ifdef VOLUME_PWM_EN
    // volume 0: at most one high cycle in any 4 consecutive cycles
    begin
      int last;
      int viol;
      volume = 2'd0;
      highs = 0; viol = 0; last = -10;
      for (int c = 0; c < 800; c++) begin
        @(negedge clk);
        if (buzzer) begin
          highs++;
          if (c - last < 4) viol++;
          last = c;
        end
      end
      check("pwm_vol0_violations", viol, 0);
      check("pwm_vol0_some_high", int'(highs > 0), 1);
      @(posedge clk); #2;
      volume = 2'd3;
    end
`endif

    tick(4);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
